err_report: RTL

Transmit-side companion to the endpoint error-status sampling logic. It accepts error events from user-side TLP engines, queues them, and signals each one to the Virtex-5 PCIe endpoint through the `cfg_err_*` reporting interface. It obeys the core's one-cycle strobe rule and its `cfg_err_cpl_rdy_n` handshake for errors that need a completion header. It sits between the DMA/TLP engines and the endpoint configuration port, in the `trn_clk` domain.

---
 rtl/err_report_pkg.sv | 40 ++++
 rtl/err_report_fifo.sv | 48 ++++
 rtl/err_report.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/err_report_pkg.sv
// Shared types and constants for the endpoint error-reporting block.
package err_report_pkg;

    localparam int unsigned TYPE_W  = 3;
    localparam int unsigned HDR_W   = 48;
    localparam int unsigned ENTRY_W = TYPE_W + 1 + 1 + HDR_W;

    typedef enum logic [TYPE_W-1:0] {
        ERR_COR         = 3'd0,
        ERR_UR          = 3'd1,
        ERR_ECRC        = 3'd2,
        ERR_CPL_TIMEOUT = 3'd3,
        ERR_CPL_ABORT   = 3'd4
    } err_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_FIRE,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic [TYPE_W-1:0] etype;
        logic              posted;
        logic              locked;
        logic [HDR_W-1:0]  hdr;
    } err_entry_t;

    // Types above CPL_ABORT have no corresponding strobe.
    function automatic logic type_legal(input logic [TYPE_W-1:0] t);
        return (t <= ERR_CPL_ABORT);
    endfunction

    // Non-posted UR / CPL_ABORT need a completion header and the rdy handshake.
    function automatic logic hdr_required(input err_entry_t e);
        return ((e.etype == ERR_UR) || (e.etype == ERR_CPL_ABORT)) && !e.posted;
    endfunction

endpackage

// File: rtl/err_report_fifo.sv
// First-word-fall-through event queue; extra pointer bit separates full from empty.
module err_report_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             trn_clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign wr_en = push & ~full;
    assign rd_en = pop & ~empty;

    // Read/write pointer advance.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage write; contents need no reset since pointers gate visibility.
    always_ff @(posedge trn_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

endmodule

// File: rtl/err_report.sv
// Queues user error events and strobes them onto the endpoint cfg_err_* port.
module err_report
    import err_report_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic               trn_clk,
    input  logic               reset_n,
    input  logic               err_valid,
    output logic               err_ready,
    input  logic [TYPE_W-1:0]  err_type,
    input  logic               err_posted,
    input  logic               err_locked,
    input  logic [HDR_W-1:0]   err_hdr,
    output logic               cfg_err_cor_n,
    output logic               cfg_err_ur_n,
    output logic               cfg_err_ecrc_n,
    output logic               cfg_err_cpl_timeout_n,
    output logic               cfg_err_cpl_abort_n,
    output logic               cfg_err_posted_n,
    output logic               cfg_err_locked_n,
    output logic [HDR_W-1:0]   cfg_err_tlp_cpl_header,
    input  logic               cfg_err_cpl_rdy_n,
    output logic               busy,
    output logic [15:0]        report_cnt,
    output logic [7:0]         drop_cnt
);

    localparam int unsigned GAP_W = 4;

    state_e             state;
    state_e             state_nxt;
    logic [GAP_W-1:0]   gap_cnt;
    err_entry_t         wr_entry;
    err_entry_t         head;
    logic [ENTRY_W-1:0] head_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               accept;
    logic               push;
    logic               drop;
    logic               pop;
    logic               fire_nxt;
    logic               head_hdr_req;

    assign wr_entry     = '{etype: err_type, posted: err_posted, locked: err_locked, hdr: err_hdr};
    assign head         = err_entry_t'(head_bits);
    assign head_hdr_req = hdr_required(head);

    assign err_ready = ~fifo_full;
    assign accept    = err_valid & ~fifo_full;
    assign push      = accept & type_legal(err_type);
    assign drop      = accept & ~type_legal(err_type);
    assign busy      = (state != ST_IDLE) | ~fifo_empty;

    err_report_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .trn_clk (trn_clk),
        .reset_n (reset_n),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (head_bits),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: hold in WAIT_RDY until the core can take a header.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_hdr_req && cfg_err_cpl_rdy_n) state_nxt = ST_WAIT_RDY;
                    else                                   state_nxt = ST_FIRE;
                end
            end
            ST_WAIT_RDY: begin
                if (!cfg_err_cpl_rdy_n) state_nxt = ST_FIRE;
            end
            ST_FIRE: begin
                pop       = 1'b1;
                state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (gap_cnt == '0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        fire_nxt = (state_nxt == ST_FIRE);
    end

    // Idle spacing counter, loaded while firing.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n)                              gap_cnt <= '0;
        else if (state == ST_FIRE)                 gap_cnt <= GAP_W'(GAP_CYCLES - 1);
        else if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
    end

    // Strobe flops: loaded from the queue head on entry to FIRE, idle otherwise.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_err_cor_n          <= 1'b1;
            cfg_err_ur_n           <= 1'b1;
            cfg_err_ecrc_n         <= 1'b1;
            cfg_err_cpl_timeout_n  <= 1'b1;
            cfg_err_cpl_abort_n    <= 1'b1;
            cfg_err_posted_n       <= 1'b1;
            cfg_err_locked_n       <= 1'b1;
            cfg_err_tlp_cpl_header <= '0;
        end else if (fire_nxt) begin
            cfg_err_cor_n          <= ~(head.etype == ERR_COR);
            cfg_err_ur_n           <= ~(head.etype == ERR_UR);
            cfg_err_ecrc_n         <= ~(head.etype == ERR_ECRC);
            cfg_err_cpl_timeout_n  <= ~(head.etype == ERR_CPL_TIMEOUT);
            cfg_err_cpl_abort_n    <= ~(head.etype == ERR_CPL_ABORT);
            cfg_err_posted_n       <= ~head.posted;
            cfg_err_locked_n       <= ~(head.locked & head_hdr_req);
            cfg_err_tlp_cpl_header <= head_hdr_req ? head.hdr : '0;
        end else begin
            cfg_err_cor_n          <= 1'b1;
            cfg_err_ur_n           <= 1'b1;
            cfg_err_ecrc_n         <= 1'b1;
            cfg_err_cpl_timeout_n  <= 1'b1;
            cfg_err_cpl_abort_n    <= 1'b1;
            cfg_err_posted_n       <= 1'b1;
            cfg_err_locked_n       <= 1'b1;
            cfg_err_tlp_cpl_header <= '0;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge trn_clk or negedge reset_n) begin
        if (!reset_n) begin
            report_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if (state == ST_FIRE && report_cnt != 16'hFFFF) report_cnt <= report_cnt + 16'd1;
            if (drop && drop_cnt != 8'hFF)                  drop_cnt   <= drop_cnt + 8'd1;
        end
    end

endmodule
